// File: rtl/capture_scheduler.sv
// Capture scheduler: round-robin arbitration between two ADC channels for a single
// capture engine, with start handshake, completion/timeout tracking and per-channel ack/err.
module capture_scheduler #(
  parameter int unsigned START_WAIT   = 16,
  parameter logic [31:0] DONE_TIMEOUT = 32'd100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [31:0] req_num0,
  input  logic [31:0] req_num1,
  input  logic        eng_busy,
  input  logic        eng_done_pulse,
  output logic        start_sample,
  output logic [31:0] set_sample_num,
  output logic        ch_sel,
  output logic [1:0]  ack,
  output logic [1:0]  err,
  output logic        sched_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  localparam logic [31:0] START_LAST = 32'(START_WAIT - 1);
  localparam logic [31:0] DONE_LAST  = DONE_TIMEOUT - 32'd1;
  localparam logic [31:0] CNT_MAX    = '1;

  state_t      state, state_nxt;
  logic        pointer;
  logic        fin_err, fin_err_nxt;
  logic [31:0] cnt;
  logic        grant_ch;
  logic [31:0] grant_num;

  // A tie goes to the channel that was not served last.
  always_comb begin
    grant_ch  = (req == 2'b11) ? ~pointer : req[1];
    grant_num = grant_ch ? req_num1 : req_num0;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_nxt   = state;
    fin_err_nxt = fin_err;
    unique case (state)
      S_IDLE: begin
        if (req != 2'b00 && !eng_busy) state_nxt = S_ARB;
      end
      S_ARB: begin
        if (req == 2'b00 || eng_busy) begin
          state_nxt = S_IDLE;
        end else if (grant_num == 32'd0) begin
          state_nxt   = S_FINISH;
          fin_err_nxt = 1'b1;
        end else begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (eng_busy) begin
          state_nxt = S_WAIT_DONE;
        end else if (cnt >= START_LAST) begin
          state_nxt   = S_FINISH;
          fin_err_nxt = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (eng_done_pulse) begin
          state_nxt   = S_FINISH;
          fin_err_nxt = 1'b0;
        end else if (cnt >= DONE_LAST) begin
          state_nxt   = S_FINISH;
          fin_err_nxt = 1'b1;
        end
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state          <= S_IDLE;
      pointer        <= 1'b1;
      fin_err        <= 1'b0;
      cnt            <= '0;
      ch_sel         <= 1'b0;
      set_sample_num <= '0;
    end else begin
      state   <= state_nxt;
      fin_err <= fin_err_nxt;

      if (state == S_ARB && state_nxt != S_IDLE) begin
        ch_sel         <= grant_ch;
        set_sample_num <= grant_num;
      end

      if (state == S_FINISH) pointer <= ch_sel;

      // Counter restarts on entry to either wait state and saturates instead of wrapping.
      if ((state_nxt == S_WAIT_BUSY && state != S_WAIT_BUSY) ||
          (state_nxt == S_WAIT_DONE && state != S_WAIT_DONE)) begin
        cnt <= '0;
      end else if ((state == S_WAIT_BUSY || state == S_WAIT_DONE) && cnt != CNT_MAX) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  always_comb begin
    start_sample = (state == S_START);
    sched_busy   = (state != S_IDLE);
    ack          = 2'b00;
    err          = 2'b00;
    if (state == S_FINISH) begin
      if (fin_err) err = {ch_sel, ~ch_sel};
      else         ack = {ch_sel, ~ch_sel};
    end
  end

endmodule
